// File: rtl/keypad_scan_control.sv
// keypad_scan_control: 4x4 keypad column scanner with frame-level debounce and 4-digit hex entry register.
// Rows are synchronised, sampled once per column dwell, and classified per 4-column frame.
module keypad_scan_control #(
    parameter int SCAN_TICKS      = 100_000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [3:0] row,
    input  logic       clear,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands
);
    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DF_C = CW'(DEBOUNCE_FRAMES);
    localparam logic DF1 = (DEBOUNCE_FRAMES == 1);

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_PRESSED, S_REL} state_t;

    state_t        r_state;
    logic [3:0]    r_sync1, r_sync2;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_cs;
    logic [1:0]    r_np;
    logic [3:0]    r_code;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic [3:0]    r_key_code;
    logic          r_valid;
    logic          r_held;
    logic [15:0]   r_digits;

    logic          w_wrap, w_frame_end, w_single, w_match, w_accept;
    logic [3:0]    w_low;
    logic [2:0]    w_cnt_col, w_sum;
    logic [1:0]    w_np, w_ridx;
    logic [3:0]    w_code;
    logic [CW-1:0] w_cnt_inc;

    assign w_wrap      = r_timer == TW'(SCAN_TICKS - 1);
    assign w_frame_end = w_wrap && r_cs == 2'd3;
    assign w_low       = ~r_sync2;
    assign w_cnt_col   = {2'b0, w_low[0]} + {2'b0, w_low[1]} + {2'b0, w_low[2]} + {2'b0, w_low[3]};
    assign w_sum       = {1'b0, r_np} + w_cnt_col;
    assign w_np        = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_ridx      = w_low[0] ? 2'd0 : w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : 2'd3;
    // The code is only meaningful when exactly one press was seen this frame
    assign w_code      = (r_np == 2'd0) ? {w_ridx, r_cs} : r_code;
    assign w_single    = w_np == 2'd1;
    assign w_match     = w_single && w_code == r_cand;
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_accept    = w_frame_end && w_single &&
                         ((r_state == S_IDLE && DF1) || (r_state == S_DEB && w_match && w_cnt_inc == DF_C));

    assign col       = ~(4'b0001 << r_cs);
    assign key_code  = r_key_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;
    assign {thousands, hundreds, tens, ones} = r_digits;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sync1    <= 4'hF;
            r_sync2    <= 4'hF;
            r_timer    <= '0;
            r_cs       <= '0;
            r_np       <= '0;
            r_code     <= '0;
            r_cnt      <= '0;
            r_cand     <= '0;
            r_key_code <= '0;
            r_valid    <= 1'b0;
            r_held     <= 1'b0;
            r_digits   <= '0;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
            r_valid <= w_accept;
            r_timer <= w_wrap ? '0 : r_timer + 1'b1;
            if (w_wrap) begin
                r_cs   <= r_cs + 2'd1;
                r_np   <= w_frame_end ? 2'd0 : w_np;
                r_code <= w_code;
            end
            if (w_accept)
                r_key_code <= w_code;
            if (clear)
                r_digits <= '0;
            else if (w_accept)
                r_digits <= {r_digits[11:0], w_code};
            if (w_frame_end) begin
                case (r_state)
                    S_IDLE: if (w_single) begin
                        r_cand  <= w_code;
                        r_cnt   <= CW'(1);
                        r_state <= DF1 ? S_PRESSED : S_DEB;
                        r_held  <= DF1;
                    end
                    S_DEB: if (w_match) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == DF_C) begin
                            r_state <= S_PRESSED;
                            r_held  <= 1'b1;
                        end
                    end else if (w_single) begin
                        r_cand <= w_code;
                        r_cnt  <= CW'(1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                    S_PRESSED: if (!w_match) begin
                        r_cnt   <= CW'(1);
                        r_state <= DF1 ? S_IDLE : S_REL;
                        r_held  <= !DF1;
                    end
                    S_REL: if (w_match) begin
                        r_state <= S_PRESSED;
                    end else if (w_cnt_inc == DF_C) begin
                        r_state <= S_IDLE;
                        r_held  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
